// File: rtl/shifter_pkg.sv
// Shared mode constants, FSM state type and active-plane helper for the planar shifter.
package shifter_pkg;

    localparam logic [1:0] REZ_LOW  = 2'd0;
    localparam logic [1:0] REZ_MED  = 2'd1;
    localparam logic [1:0] REZ_HIGH = 2'd2;

    typedef enum logic {IDLE, RUN} state_t;

    // rez=3 behaves as high resolution; never fewer than one active plane.
    function automatic int np_of(input logic [1:0] rez, input int planes);
        int r;
        int n;
        r = (rez == 2'd3) ? 2 : int'(rez);
        n = planes >> r;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/shifter_load_stage.sv
// Bus-word staging: collects PLANES words into a group, flags completion and overrun.
// Latency: group_ready one cycle after the completing load; o_stg_nxt/o_bypass are combinational.
// Backpressure: none; a load arriving while a full group is pending is dropped and flagged.
module shifter_load_stage #(
    parameter int PLANES = 4,
    parameter int WIDTH  = 16
) (
    input  logic                          i_clk32,
    input  logic                          i_reset,
    input  logic                          i_de,
    input  logic                          i_load,
    input  logic [WIDTH-1:0]              i_din,
    input  logic                          i_reload,
    input  logic                          i_status_clr,
    output logic [PLANES-1:0][WIDTH-1:0]  o_stg,
    output logic [PLANES-1:0][WIDTH-1:0]  o_stg_nxt,
    output logic                          o_group_ready,
    output logic                          o_bypass,
    output logic                          o_overrun
);

    localparam int CW = $clog2(PLANES);
    localparam logic [CW-1:0] LAST = CW'(PLANES - 1);

    logic [PLANES-1:0][WIDTH-1:0] r_stg;
    logic [CW-1:0]                r_cnt;
    logic                         r_group_ready;
    logic                         r_overrun;
    logic                         w_accept;
    logic                         w_complete;
    logic                         w_overrun_evt;

    // A reload in the same cycle frees the pending group, so the word may start the next one.
    always_comb begin
        o_stg_nxt     = {i_din, r_stg[PLANES-1:1]};
        w_accept      = i_load && i_de && (!r_group_ready || i_reload);
        w_complete    = w_accept && (r_cnt == LAST);
        o_bypass      = i_load && i_de && !r_group_ready && (r_cnt == LAST);
        w_overrun_evt = i_load && r_group_ready && !i_reload;
    end

    always_ff @(posedge i_clk32) begin
        if (i_reset) begin
            r_stg         <= '0;
            r_cnt         <= '0;
            r_group_ready <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (!i_de) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stg <= o_stg_nxt;
                r_cnt <= w_complete ? '0 : r_cnt + CW'(1);
            end

            if (i_reload)
                r_group_ready <= 1'b0;
            else if (w_complete)
                r_group_ready <= 1'b1;

            if (w_overrun_evt)
                r_overrun <= 1'b1;
            else if (i_status_clr)
                r_overrun <= 1'b0;
        end
    end

    assign o_stg         = r_stg;
    assign o_group_ready = r_group_ready;
    assign o_overrun     = r_overrun;

endmodule

// File: rtl/shifter_video_planar.sv
// Bitplane serialiser: reloads staged groups into per-plane shift chains, one color index per pix_ce.
// Latency: zero pixel latency after the reload edge; color_index registered.
// Backpressure: none; missing groups flag underrun, surplus loads flag overrun.
module shifter_video_planar
    import shifter_pkg::*;
#(
    parameter int PLANES = 4,
    parameter int WIDTH  = 16
) (
    input  logic              i_clk32,
    input  logic              i_reset,
    input  logic              i_pix_ce,
    input  logic              i_de,
    input  logic              i_load,
    input  logic [WIDTH-1:0]  i_din,
    input  logic [1:0]        i_rez,
    input  logic              i_monocolor,
    input  logic              i_status_clr,
    output logic [PLANES-1:0] o_color_index,
    output logic              o_reload,
    output logic              o_underrun,
    output logic              o_overrun
);

    localparam int PCW      = $clog2(WIDTH * PLANES);
    localparam int LEN_LOW  = WIDTH * PLANES / np_of(REZ_LOW,  PLANES);
    localparam int LEN_MED  = WIDTH * PLANES / np_of(REZ_MED,  PLANES);
    localparam int LEN_HIGH = WIDTH * PLANES / np_of(REZ_HIGH, PLANES);
    localparam logic [PCW-1:0] LENM1_LOW  = PCW'(LEN_LOW  - 1);
    localparam logic [PCW-1:0] LENM1_MED  = PCW'(LEN_MED  - 1);
    localparam logic [PCW-1:0] LENM1_HIGH = PCW'(LEN_HIGH - 1);

    logic [PLANES-1:0][WIDTH-1:0] r_chn;
    logic [PCW-1:0]               r_pcnt;
    logic [1:0]                   r_rez_q;
    state_t                       r_state;
    logic                         r_underrun;

    logic [PLANES-1:0][WIDTH-1:0] w_stg;
    logic [PLANES-1:0][WIDTH-1:0] w_stg_nxt;
    logic [PLANES-1:0][WIDTH-1:0] w_src;
    logic [PLANES-1:0][WIDTH-1:0] w_shift;
    logic                         w_group_ready;
    logic                         w_bypass;
    logic                         w_avail;
    logic                         w_last;
    logic                         w_do_reload;
    logic                         w_underrun_evt;
    logic                         w_fill;
    logic                         w_tail;
    logic [PCW-1:0]               w_len_m1;
    logic [PLANES-1:0]            w_idx_src;
    logic [PLANES-1:0]            w_idx_shift;
    logic [PLANES-1:0]            w_idx_idle;
    int                           w_np;
    int                           w_np_new;

    shifter_load_stage #(.PLANES(PLANES), .WIDTH(WIDTH)) u_load (
        .i_clk32       (i_clk32),
        .i_reset       (i_reset),
        .i_de          (i_de),
        .i_load        (i_load),
        .i_din         (i_din),
        .i_reload      (w_do_reload),
        .i_status_clr  (i_status_clr),
        .o_stg         (w_stg),
        .o_stg_nxt     (w_stg_nxt),
        .o_group_ready (w_group_ready),
        .o_bypass      (w_bypass),
        .o_overrun     (o_overrun)
    );

    always_comb begin
        w_np     = np_of(r_rez_q, PLANES);
        w_np_new = np_of(i_rez, PLANES);
        w_fill   = (r_rez_q >= REZ_HIGH) && !i_monocolor;
        case (r_rez_q)
            REZ_LOW: w_len_m1 = LENM1_LOW;
            REZ_MED: w_len_m1 = LENM1_MED;
            default: w_len_m1 = LENM1_HIGH;
        endcase
        w_last         = (r_pcnt == w_len_m1);
        w_avail        = w_group_ready || w_bypass;
        w_do_reload    = i_pix_ce && w_avail && ((r_state == IDLE) || w_last);
        w_underrun_evt = i_pix_ce && (r_state == RUN) && w_last && !w_avail && i_de;
        w_src          = w_bypass ? w_stg_nxt : w_stg;

        // Plane p feeds from plane p+NP, so each active chain runs stg[j], stg[j+NP], ...
        w_tail  = 1'b0;
        w_shift = '0;
        for (int p = 0; p < PLANES; p++) begin
            w_tail = w_fill;
            for (int q = 0; q < PLANES; q++) begin
                if (q == p + w_np)
                    w_tail = r_chn[q][WIDTH-1];
            end
            w_shift[p] = {r_chn[p][WIDTH-2:0], w_tail};
        end

        w_idx_src   = '0;
        w_idx_shift = '0;
        for (int j = 0; j < PLANES; j++) begin
            if (j < w_np_new) w_idx_src[j]   = w_src[j][WIDTH-1];
            if (j < w_np)     w_idx_shift[j] = w_shift[j][WIDTH-1];
        end
        w_idx_idle = {{(PLANES-1){1'b0}}, w_fill};
    end

    always_ff @(posedge i_clk32) begin
        if (i_reset) begin
            r_chn         <= '0;
            r_pcnt        <= '0;
            r_rez_q       <= REZ_LOW;
            r_state       <= IDLE;
            r_underrun    <= 1'b0;
            o_color_index <= '0;
            o_reload      <= 1'b0;
        end else begin
            o_reload <= w_do_reload;
            if (w_do_reload) begin
                r_chn         <= w_src;
                r_rez_q       <= i_rez;
                r_pcnt        <= '0;
                r_state       <= RUN;
                o_color_index <= w_idx_src;
            end else if (i_pix_ce) begin
                if ((r_state == RUN) && !w_last) begin
                    r_chn         <= w_shift;
                    r_pcnt        <= r_pcnt + PCW'(1);
                    o_color_index <= w_idx_shift;
                end else begin
                    r_state       <= IDLE;
                    o_color_index <= w_idx_idle;
                end
            end

            if (w_underrun_evt)
                r_underrun <= 1'b1;
            else if (i_status_clr)
                r_underrun <= 1'b0;
        end
    end

    assign o_underrun = r_underrun;

endmodule

// File: tb/tb_shifter_video_planar.sv
// Directed bench for shifter_video_planar: vector table plus hand-written multi-cycle sequences.
module tb_shifter_video_planar;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_pix_ce = 1'b0;
    logic        i_de = 1'b1;
    logic        i_load = 1'b0;
    logic [15:0] i_din = '0;
    logic [1:0]  i_rez = 2'd0;
    logic        i_monocolor = 1'b0;
    logic        i_status_clr = 1'b0;
    logic [3:0]  o_color_index;
    logic        o_reload;
    logic        o_underrun;
    logic        o_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shifter_video_planar #(.PLANES(4), .WIDTH(16)) dut (
        .i_clk32       (clk),
        .i_reset       (i_reset),
        .i_pix_ce      (i_pix_ce),
        .i_de          (i_de),
        .i_load        (i_load),
        .i_din         (i_din),
        .i_rez         (i_rez),
        .i_monocolor   (i_monocolor),
        .i_status_clr  (i_status_clr),
        .o_color_index (o_color_index),
        .o_reload      (o_reload),
        .o_underrun    (o_underrun),
        .o_overrun     (o_overrun)
    );

    typedef struct {
        logic [1:0]  rez;
        logic        mono;
        logic [15:0] w0, w1, w2, w3;
        int          pix;
        logic [3:0]  idx;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic pce, input logic ld, input logic [15:0] d);
        i_pix_ce = pce;
        i_load   = ld;
        i_din    = d;
        @(posedge clk);
        #1;
        i_pix_ce     = 1'b0;
        i_load       = 1'b0;
        i_status_clr = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        i_reset = 1'b0;
    endtask

    task automatic load4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        step(1'b0, 1'b1, a);
        step(1'b0, 1'b1, b);
        step(1'b0, 1'b1, c);
        step(1'b0, 1'b1, d);
    endtask

    task automatic pix(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, 1'b0, 16'h0);
            step(1'b0, 1'b0, 16'h0);
        end
    endtask

    initial begin
        vt[0]  = '{2'd0, 1'b0, 16'h8000, 16'h0000, 16'h0000, 16'h0000,  0, 4'h1};
        vt[1]  = '{2'd0, 1'b0, 16'h8000, 16'h0000, 16'h0000, 16'h0000,  1, 4'h0};
        vt[2]  = '{2'd0, 1'b0, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 15, 4'h0};
        vt[3]  = '{2'd1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF,  0, 4'h1};
        vt[4]  = '{2'd1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16, 4'h2};
        vt[5]  = '{2'd1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 31, 4'h2};
        vt[6]  = '{2'd2, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA,  0, 4'h1};
        vt[7]  = '{2'd2, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA,  1, 4'h0};
        vt[8]  = '{2'd2, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 62, 4'h1};
        vt[9]  = '{2'd2, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 63, 4'h0};
        vt[10] = '{2'd0, 1'b0, 16'h8000, 16'h8000, 16'h8000, 16'h8000,  0, 4'hF};
        vt[11] = '{2'd0, 1'b0, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 15, 4'h5};
        vt[12] = '{2'd1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 15, 4'h1};
        vt[13] = '{2'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 63, 4'h1};
        vt[14] = '{2'd2, 1'b1, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA,  0, 4'h1};

        do_reset();
        chk("reset_idx", 32'(o_color_index), 32'h0);
        chk("reset_reload", 32'(o_reload), 32'h0);
        chk("reset_underrun", 32'(o_underrun), 32'h0);
        chk("reset_overrun", 32'(o_overrun), 32'h0);

        for (int v = 0; v < 15; v++) begin
            do_reset();
            i_rez = vt[v].rez;
            i_monocolor = vt[v].mono;
            i_de = 1'b1;
            load4(vt[v].w0, vt[v].w1, vt[v].w2, vt[v].w3);
            step(1'b1, 1'b0, 16'h0);
            chk($sformatf("vec%0d_reload", v), 32'(o_reload), 32'h1);
            step(1'b0, 1'b0, 16'h0);
            pix(vt[v].pix);
            chk($sformatf("vec%0d_idx", v), 32'(o_color_index), 32'(vt[v].idx));
        end

        // End of low group with nothing staged: underrun, back to IDLE
        do_reset();
        i_rez = 2'd0; i_monocolor = 1'b0; i_de = 1'b1;
        load4(16'h8000, 16'h0000, 16'h0000, 16'h0000);
        pix(16);
        chk("ur_pre", 32'(o_underrun), 32'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("ur_reload", 32'(o_reload), 32'h0);
        chk("ur_flag", 32'(o_underrun), 32'h1);
        chk("ur_idle_idx", 32'(o_color_index), 32'h0);
        i_status_clr = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        chk("ur_clear", 32'(o_underrun), 32'h0);

        // Bypass: 4th word together with the last-pixel pix_ce
        do_reset();
        load4(16'h8000, 16'h0000, 16'h0000, 16'h0000);
        pix(1);
        step(1'b0, 1'b1, 16'h8000);
        step(1'b0, 1'b1, 16'h8000);
        step(1'b0, 1'b1, 16'h0000);
        pix(15);
        step(1'b1, 1'b1, 16'h8000);
        chk("byp_reload", 32'(o_reload), 32'h1);
        chk("byp_idx", 32'(o_color_index), 32'hB);
        chk("byp_underrun", 32'(o_underrun), 32'h0);
        chk("byp_overrun", 32'(o_overrun), 32'h0);
        load4(16'h0000, 16'h0000, 16'h0000, 16'h8000);
        step(1'b0, 1'b1, 16'hFFFF);
        chk("ovr_flag", 32'(o_overrun), 32'h1);
        pix(15);
        step(1'b1, 1'b0, 16'h0);
        chk("ovr_reload", 32'(o_reload), 32'h1);
        chk("ovr_dropped_idx", 32'(o_color_index), 32'h8);
        load4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        i_status_clr = 1'b1;
        step(1'b0, 1'b1, 16'h1234);
        chk("ovr_event_wins", 32'(o_overrun), 32'h1);
        i_status_clr = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        chk("ovr_clear", 32'(o_overrun), 32'h0);

        // de drop discards a partial group; de low at end of line means no underrun
        do_reset();
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b1, 16'hFFFF);
        i_de = 1'b0;
        step(1'b0, 1'b0, 16'h0);
        i_de = 1'b1;
        load4(16'h8000, 16'h0000, 16'h0000, 16'h0000);
        step(1'b1, 1'b0, 16'h0);
        chk("de_reload", 32'(o_reload), 32'h1);
        chk("de_idx", 32'(o_color_index), 32'h1);
        chk("de_overrun", 32'(o_overrun), 32'h0);
        i_de = 1'b0;
        pix(16);
        chk("de_no_underrun", 32'(o_underrun), 32'h0);
        i_de = 1'b1;

        // High-mode IDLE fill follows monocolor
        do_reset();
        i_rez = 2'd2; i_monocolor = 1'b0;
        load4(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
        pix(65);
        chk("hi_idle_idx", 32'(o_color_index), 32'h1);
        chk("hi_underrun", 32'(o_underrun), 32'h1);
        i_monocolor = 1'b1;
        pix(1);
        chk("hi_idle_mono", 32'(o_color_index), 32'h0);
        i_monocolor = 1'b0;

        // Reset in the middle of a run
        do_reset();
        i_rez = 2'd0;
        load4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        pix(17);
        load4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step(1'b0, 1'b1, 16'h0);
        pix(2);
        chk("rst_pre_idx", 32'(o_color_index), 32'hF);
        chk("rst_pre_flags", 32'({o_underrun, o_overrun}), 32'h3);
        do_reset();
        chk("rst_idx", 32'(o_color_index), 32'h0);
        chk("rst_flags", 32'({o_underrun, o_overrun}), 32'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("rst_idle_reload", 32'(o_reload), 32'h0);
        chk("rst_idle_idx", 32'(o_color_index), 32'h0);

        // rez change mid-group only takes effect at the next reload
        do_reset();
        i_rez = 2'd0;
        load4(16'h8000, 16'h0000, 16'h0000, 16'h0000);
        pix(1);
        i_rez = 2'd1;
        load4(16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF);
        pix(15);
        chk("rez_old_idx", 32'(o_color_index), 32'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("rez_low_len", 32'(o_reload), 32'h1);
        chk("rez_med_idx0", 32'(o_color_index), 32'h1);
        step(1'b0, 1'b0, 16'h0);
        load4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        pix(16);
        chk("rez_med_idx16", 32'(o_color_index), 32'h2);
        pix(14);
        step(1'b1, 1'b0, 16'h0);
        chk("rez_med_no_early", 32'(o_reload), 32'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("rez_med_len", 32'(o_reload), 32'h1);
        chk("rez_final_underrun", 32'(o_underrun), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
